// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/flopenr.sv
`default_nettype none
// ============================================================================
// Module      : flopenr
// Description : Width-parameterised register with synchronous reset and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule : flopenr
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Single-outstanding instruction fetch with PC, hold register
//               and downstream redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] c_RESET_PC = {RESET_PC[31:2], 2'b00};

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic        w_handoff;
  logic        w_resp_take;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_count_next;
  logic        r_misalign;

  assign w_handoff   = (r_state == HOLD) && instr_ready;
  assign w_resp_take = (r_state == WAIT) && imem_resp_valid;
  assign w_pc_plus4  = pc + 32'd4;
  assign w_pc_next   = redirect ? {redirect_pc[31:2], 2'b00} : w_pc_plus4;
  assign w_count_next = fetch_count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: w_next_state = REQ;
      REQ:  if (imem_req_ready) w_next_state = WAIT;
      WAIT: if (imem_resp_valid) w_next_state = HOLD;
      HOLD: if (instr_ready) w_next_state = REQ;
      default: w_next_state = IDLE;
    endcase
  end

  flopenr #(.WIDTH(32), .RESET_VAL(c_RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (reset),
    .i_en (w_handoff),
    .i_d  (w_pc_next),
    .o_q  (pc)
  );

  flopenr #(.WIDTH(32), .RESET_VAL(NOP_INSTR)) u_instr_reg (
    .clk  (clk),
    .rst  (reset),
    .i_en (w_resp_take),
    .i_d  (imem_resp_data),
    .o_q  (instr)
  );

  flopenr #(.WIDTH(32), .RESET_VAL(32'd0)) u_count_reg (
    .clk  (clk),
    .rst  (reset),
    .i_en (w_handoff),
    .i_d  (w_count_next),
    .o_q  (fetch_count)
  );

  // Only a redirect actually taken at handoff can raise the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (w_handoff && redirect && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign imem_req_valid = (r_state == REQ);
  assign instr_valid    = (r_state == HOLD);
  assign imem_addr      = pc;
  assign pc_plus4       = w_pc_plus4;
  assign misalign       = r_misalign;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed scoreboard bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic [31:0] fetch_count;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int cyc      = 0;
  int valid_cyc = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        exp_mis;
  logic [63:0] sb[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .misalign        (misalign),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) n_acc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'h8C00_1111);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!imem_req_valid && t < 20) begin
      tick();
      t++;
    end
    check("req_timeout", {31'b0, imem_req_valid}, 32'd1);
  endtask

  // One instruction: request stall, response latency, downstream hold, handoff.
  task automatic fetch(input int rdly, input int resp_dly, input int hold,
                       input logic redir, input logic [31:0] rpc);
    int          acc0;
    logic [31:0] a;
    logic [63:0] e;
    wait_req();
    check("req_addr", imem_addr, exp_pc);
    a    = imem_addr;
    acc0 = n_acc;
    for (int i = 0; i < rdly; i++) begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_0000 + i;
      instr_ready     = 1'b1;
      redirect        = 1'b1;
      redirect_pc     = 32'h0000_0203;
      tick();
      check("req_stall_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_addr_stable", imem_addr, a);
      check("req_stall_count", fetch_count, exp_cnt);
    end
    imem_resp_valid = 1'b0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    sb.push_back({a, mem_word(a)});
    check("req_drop", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 1; i < resp_dly; i++) begin
      tick();
      check("early_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_word(a);
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
    valid_cyc = cyc;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    check("one_accept", n_acc - acc0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("hold_pc", pc, e[63:32]);
      check("hold_instr", instr, e[31:0]);
      check("hold_pc_plus4", pc_plus4, e[63:32] + 32'd4);
    end else begin
      check("sb_empty", 32'd0, 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_instr_stable", instr, mem_word(a));
      check("hold_pc_stable", pc, a);
      check("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
      check("hold_count", fetch_count, exp_cnt);
    end
    instr_ready = 1'b1;
    redirect    = redir;
    redirect_pc = rpc;
    tick();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    exp_cnt = exp_cnt + 32'd1;
    exp_pc  = redir ? {rpc[31:2], 2'b00} : (a + 32'd4);
    if (redir && rpc[1:0] != 2'b00) exp_mis = 1'b1;
    check("post_valid", {31'b0, instr_valid}, 32'd0);
    check("post_req", {31'b0, imem_req_valid}, 32'd1);
    check("next_addr", imem_addr, exp_pc);
    check("post_count", fetch_count, exp_cnt);
    check("post_misalign", {31'b0, misalign}, {31'b0, exp_mis});
  endtask

  initial begin
    int rel_cyc;
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    exp_pc  = 32'h0;
    exp_cnt = 32'd0;
    exp_mis = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    rel_cyc = cyc;
    check_reset_state();

    // Zero-wait memory, first instruction latency from reset release.
    fetch(0, 1, 0, 1'b0, 32'h0);
    check("first_latency", valid_cyc - rel_cyc, 32'd3);

    // Request stall of 4 cycles, response 3 cycles after acceptance.
    fetch(4, 3, 0, 1'b0, 32'h0);

    // Downstream back-pressure for 5 cycles.
    fetch(0, 1, 5, 1'b0, 32'h0);

    // Aligned redirect; redirect toggled while holding must be ignored.
    fetch(0, 1, 2, 1'b1, 32'h0000_0040);

    // Misaligned redirect target.
    fetch(0, 1, 0, 1'b1, 32'h0000_0042);
    fetch(0, 1, 1, 1'b0, 32'h0);

    // Wrap of pc from the top of the address space.
    fetch(0, 1, 0, 1'b1, 32'hFFFF_FFFE);
    fetch(0, 1, 0, 1'b0, 32'h0);

    // Reset while waiting, with a response in the same cycle.
    wait_req();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    reset           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_word(imem_addr);
    tick();
    reset           = 1'b0;
    imem_resp_valid = 1'b0;
    check_reset_state();
    sb.delete();
    exp_pc  = 32'h0;
    exp_cnt = 32'd0;
    exp_mis = 1'b0;
    fetch(1, 2, 1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
